// File: rtl/serdes_chk_pkg.sv
// Shared definitions for the SerDes link test pattern: FSM states, pattern
// characters and K28.5 line codes (also used by the TX-side generator).
package serdes_chk_pkg;

   typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} state_t;

   localparam logic [7:0] K28_5     = 8'hBC;
   localparam logic [7:0] FILL_4A   = 8'h4A;
   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;

   function automatic logic [3:0] count_ones8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/serdes_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module serdes_sat_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serdes_rx_pattern_checker.sv
// RX pattern checker: finds the K28.5 lane, qualifies lock and counts good/bad words.
// Define SERDES_CHK_CODE_ERR_EN to also treat 8b/10b code/disparity errors as bad words.
module serdes_rx_pattern_checker
   import serdes_chk_pkg::*;
#(
   parameter logic [7:0] K_CHAR     = K28_5,
   parameter logic [7:0] FILL_CHAR  = FILL_4A,
   parameter int         LOCK_CNT   = 8,
   parameter int         UNLOCK_CNT = 4,
   parameter int         CNT_W      = 32
) (
   input  logic             rx_clk,
   input  logic             rx_rstn_i,
   input  logic             rx_en_i,
   input  logic             clr_cnt_i,
   input  logic [63:0]      rx_data_i,
   input  logic [7:0]       rx_char_is_k_i,
   input  logic [7:0]       rx_not_in_table_i,
   input  logic [7:0]       rx_disp_err_i,
   output logic             locked_o,
   output logic [2:0]       comma_lane_o,
   output logic             err_o,
   output logic [CNT_W-1:0] word_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [7:0]       lock_loss_cnt_o
);

   logic        vld_p1;
   logic        clr_p1;
   logic [63:0] data_p1;
   logic [7:0]  k_p1;
   logic [7:0]  code_err_p1;

   state_t      state_p2;
   logic [2:0]  lane_p2;
   logic [7:0]  good_run_p2;
   logic [7:0]  bad_run_p2;

   logic        word_good;
   logic        comma_hit;
   logic [2:0]  hit_lane;
   logic [3:0]  k_count;
   logic [7:0]  good_run_nxt;
   logic [7:0]  bad_run_nxt;
   logic        word_inc;
   logic        err_inc;
   logic        loss_inc;

   // Stage 1: register the RX interface
   always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
      if (!rx_rstn_i) begin
         vld_p1 <= 1'b0;
         clr_p1 <= 1'b0;
      end else begin
         vld_p1 <= rx_en_i;
         clr_p1 <= clr_cnt_i;
      end
   end

   always_ff @(posedge rx_clk) begin
      data_p1 <= rx_data_i;
      k_p1    <= rx_char_is_k_i;
   end

`ifdef SERDES_CHK_CODE_ERR_EN
   always_ff @(posedge rx_clk) begin
      code_err_p1 <= rx_not_in_table_i | rx_disp_err_i;
   end
`else
   logic unused_code_err;
   assign unused_code_err = ^{rx_not_in_table_i, rx_disp_err_i};
   assign code_err_p1     = 8'h00;
`endif

   // Stage 2: evaluate the word against the locked lane and search for a comma
   always_comb begin
      word_good = 1'b1;
      hit_lane  = 3'd0;
      for (int n = 0; n < 8; n++) begin
         if (3'(n) == lane_p2) begin
            if ((data_p1[8*n +: 8] != K_CHAR) || !k_p1[n]) word_good = 1'b0;
         end else if ((data_p1[8*n +: 8] != FILL_CHAR) || k_p1[n]) begin
            word_good = 1'b0;
         end
         if (k_p1[n]) hit_lane = 3'(n);
      end
      if (code_err_p1 != 8'h00) word_good = 1'b0;

      k_count   = count_ones8(k_p1);
      comma_hit = (k_count == 4'd1) && (data_p1[{hit_lane, 3'b000} +: 8] == K_CHAR) &&
                  !code_err_p1[hit_lane];

      good_run_nxt = good_run_p2 + 8'd1;
      bad_run_nxt  = bad_run_p2 + 8'd1;
      word_inc     = vld_p1 && (state_p2 == LOCKED);
      err_inc      = word_inc && !word_good;
      loss_inc     = err_inc && (bad_run_nxt == 8'(UNLOCK_CNT));
   end

   always_ff @(posedge rx_clk or negedge rx_rstn_i) begin
      if (!rx_rstn_i) begin
         state_p2     <= IDLE;
         lane_p2      <= 3'd0;
         good_run_p2  <= 8'd0;
         bad_run_p2   <= 8'd0;
         locked_o     <= 1'b0;
         comma_lane_o <= 3'd0;
         err_o        <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if (!vld_p1) begin
            state_p2     <= IDLE;
            good_run_p2  <= 8'd0;
            bad_run_p2   <= 8'd0;
            locked_o     <= 1'b0;
            comma_lane_o <= 3'd0;
         end else begin
            case (state_p2)
               IDLE: state_p2 <= SEARCH;
               SEARCH: begin
                  if (comma_hit) begin
                     lane_p2      <= hit_lane;
                     comma_lane_o <= hit_lane;
                     good_run_p2  <= 8'd1;
                     bad_run_p2   <= 8'd0;
                     if (LOCK_CNT == 1) begin
                        state_p2 <= LOCKED;
                        locked_o <= 1'b1;
                     end else begin
                        state_p2 <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (word_good) begin
                     good_run_p2 <= good_run_nxt;
                     if (good_run_nxt == 8'(LOCK_CNT)) begin
                        state_p2   <= LOCKED;
                        locked_o   <= 1'b1;
                        bad_run_p2 <= 8'd0;
                     end
                  end else begin
                     // the failing word is not searched again; next word is
                     state_p2     <= SEARCH;
                     comma_lane_o <= 3'd0;
                  end
               end
               LOCKED: begin
                  if (word_good) begin
                     bad_run_p2 <= 8'd0;
                  end else begin
                     err_o <= 1'b1;
                     if (bad_run_nxt == 8'(UNLOCK_CNT)) begin
                        state_p2     <= SEARCH;
                        locked_o     <= 1'b0;
                        comma_lane_o <= 3'd0;
                        bad_run_p2   <= 8'd0;
                     end else begin
                        bad_run_p2 <= bad_run_nxt;
                     end
                  end
               end
               default: state_p2 <= IDLE;
            endcase
         end
      end
   end

   serdes_sat_cnt #(.W(CNT_W)) u_word_cnt (
      .clk   (rx_clk),
      .rst_n (rx_rstn_i),
      .inc   (word_inc),
      .clr   (clr_p1),
      .cnt   (word_cnt_o)
   );

   serdes_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk   (rx_clk),
      .rst_n (rx_rstn_i),
      .inc   (err_inc),
      .clr   (clr_p1),
      .cnt   (err_cnt_o)
   );

   serdes_sat_cnt #(.W(8)) u_loss_cnt (
      .clk   (rx_clk),
      .rst_n (rx_rstn_i),
      .inc   (loss_inc),
      .clr   (clr_p1),
      .cnt   (lock_loss_cnt_o)
   );

endmodule

// File: tb/tb_serdes_rx_pattern_checker.sv
// Self-checking bench for serdes_rx_pattern_checker with a word-level reference model.
// Honours SERDES_CHK_CODE_ERR_EN the same way as the design.
module tb_serdes_rx_pattern_checker;

   localparam int         LOCK_CNT   = 8;
   localparam int         UNLOCK_CNT = 4;
   localparam int         CW         = 10;
   localparam logic [7:0] K          = 8'hBC;
   localparam logic [7:0] FILL       = 8'h4A;
`ifdef SERDES_CHK_CODE_ERR_EN
   localparam bit CE_EN = 1'b1;
`else
   localparam bit CE_EN = 1'b0;
`endif

   logic          rx_clk = 1'b0;
   logic          rx_rstn_i;
   logic          rx_en_i;
   logic          clr_cnt_i;
   logic [63:0]   rx_data_i;
   logic [7:0]    rx_char_is_k_i;
   logic [7:0]    rx_not_in_table_i;
   logic [7:0]    rx_disp_err_i;
   logic          locked_o;
   logic [2:0]    comma_lane_o;
   logic          err_o;
   logic [CW-1:0] word_cnt_o;
   logic [CW-1:0] err_cnt_o;
   logic [7:0]    lock_loss_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   serdes_rx_pattern_checker #(
      .K_CHAR(K), .FILL_CHAR(FILL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CW)
   ) dut (
      .rx_clk            (rx_clk),
      .rx_rstn_i         (rx_rstn_i),
      .rx_en_i           (rx_en_i),
      .clr_cnt_i         (clr_cnt_i),
      .rx_data_i         (rx_data_i),
      .rx_char_is_k_i    (rx_char_is_k_i),
      .rx_not_in_table_i (rx_not_in_table_i),
      .rx_disp_err_i     (rx_disp_err_i),
      .locked_o          (locked_o),
      .comma_lane_o      (comma_lane_o),
      .err_o             (err_o),
      .word_cnt_o        (word_cnt_o),
      .err_cnt_o         (err_cnt_o),
      .lock_loss_cnt_o   (lock_loss_cnt_o)
   );

   always #5 rx_clk = ~rx_clk;

   // Reference model: one word per clock, outputs appear two edges after the word
   int            m_mode;   // 0 idle, 1 search, 2 verify, 3 locked
   int            m_L, m_good, m_bad;
   logic          m_locked, m_err;
   logic [2:0]    m_lane;
   logic [CW-1:0] m_word, m_errc;
   logic [7:0]    m_loss;
   logic          p_en, p_clr;
   logic [63:0]   p_d;
   logic [7:0]    p_k, p_ce;

   function automatic logic [63:0] pat_d(input int lane);
      logic [63:0] v;
      v = {8{FILL}};
      v[8*lane +: 8] = K;
      return v;
   endfunction

   function automatic logic [7:0] pat_k(input int lane);
      logic [7:0] v;
      v = 8'h00;
      v[lane] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_L = 0; m_good = 0; m_bad = 0;
      m_locked = 1'b0; m_err = 1'b0; m_lane = 3'd0;
      m_word = '0; m_errc = '0; m_loss = 8'd0;
      p_en = 1'b0; p_clr = 1'b0; p_d = '0; p_k = '0; p_ce = '0;
   endtask

   task automatic model_edge(input logic en, input logic clr, input logic [63:0] d,
                             input logic [7:0] k, input logic [7:0] ce);
      bit good, hit, inc_w, inc_e, inc_l;
      int hl;
      inc_w = 0; inc_e = 0; inc_l = 0; m_err = 1'b0;
      good = (p_d == pat_d(m_L)) && (p_k == pat_k(m_L)) && (!CE_EN || p_ce == 8'h00);
      hl = 0;
      for (int i = 0; i < 8; i++) if (p_k[i]) hl = i;
      hit = ($countones(p_k) == 1) && (p_d[8*hl +: 8] == K) && (!CE_EN || !p_ce[hl]);
      if (!p_en) begin
         m_mode = 0; m_locked = 1'b0; m_lane = 3'd0;
      end else begin
         case (m_mode)
            0: m_mode = 1;
            1: if (hit) begin
                  m_L = hl; m_lane = 3'(hl); m_good = 1; m_bad = 0;
                  if (m_good >= LOCK_CNT) begin m_mode = 3; m_locked = 1'b1; end
                  else m_mode = 2;
               end
            2: if (good) begin
                  m_good++;
                  if (m_good == LOCK_CNT) begin m_mode = 3; m_locked = 1'b1; m_bad = 0; end
               end else begin
                  m_mode = 1; m_lane = 3'd0;
               end
            default: begin
               inc_w = 1;
               if (good) m_bad = 0;
               else begin
                  inc_e = 1; m_err = 1'b1; m_bad++;
                  if (m_bad == UNLOCK_CNT) begin
                     inc_l = 1; m_mode = 1; m_locked = 1'b0; m_lane = 3'd0; m_bad = 0;
                  end
               end
            end
         endcase
      end
      if (p_clr) begin
         m_word = '0; m_errc = '0; m_loss = 8'd0;
      end else begin
         if (inc_w && m_word != '1) m_word++;
         if (inc_e && m_errc != '1) m_errc++;
         if (inc_l && m_loss != 8'hFF) m_loss++;
      end
      p_en = en; p_clr = clr; p_d = d; p_k = k; p_ce = ce;
   endtask

   task automatic step(input logic en, input logic clr, input logic [63:0] d, input logic [7:0] k,
                       input logic [7:0] nit, input logic [7:0] de);
      rx_en_i = en; clr_cnt_i = clr; rx_data_i = d; rx_char_is_k_i = k;
      rx_not_in_table_i = nit; rx_disp_err_i = de;
      @(posedge rx_clk);
      model_edge(en, clr, d, k, nit | de);
      #1;
   endtask

   task automatic good_step(input int lane);
      step(1'b1, 1'b0, pat_d(lane), pat_k(lane), 8'h00, 8'h00);
   endtask

   task automatic async_reset_pulse();
      rx_rstn_i = 1'b0;
      #2;
      rx_rstn_i = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rx_rstn_i = 1'b0; rx_en_i = 1'b0; clr_cnt_i = 1'b0; rx_data_i = '0;
      rx_char_is_k_i = '0; rx_not_in_table_i = '0; rx_disp_err_i = '0;
      model_reset();
      repeat (3) @(posedge rx_clk);
      #1;
      n_checks++;
      if ({locked_o, comma_lane_o, err_o} !== 5'd0) begin
         n_errors++; $display("FAIL reset_flags got=%b want=00000", {locked_o, comma_lane_o, err_o});
      end
      n_checks++;
      if (word_cnt_o !== '0 || err_cnt_o !== '0) begin
         n_errors++; $display("FAIL reset_counts got word=%0d err=%0d want 0", word_cnt_o, err_cnt_o);
      end
      n_checks++;
      if (lock_loss_cnt_o !== 8'd0) begin
         n_errors++; $display("FAIL reset_loss got=%0d want=0", lock_loss_cnt_o);
      end
      rx_rstn_i = 1'b1;
   endtask

   task automatic test_lane0_lock();
      for (int n = 1; n <= 12; n++) begin
         good_step(0);
         n_checks++;
         if (locked_o !== (n >= 2 + LOCK_CNT)) begin
            n_errors++; $display("FAIL lock_time cycle=%0d locked_o=%b want=%b", n, locked_o, (n >= 2 + LOCK_CNT));
         end
      end
      n_checks++;
      if (comma_lane_o !== 3'd0 || err_cnt_o !== '0) begin
         n_errors++; $display("FAIL lane0_status lane=%0d err_cnt=%0d want lane=0 err_cnt=0", comma_lane_o, err_cnt_o);
      end
   endtask

   task automatic test_lane_switch();
      int n, pulses;
      async_reset_pulse();
      n = 0;
      while (locked_o !== 1'b1 && n < 30) begin good_step(5); n++; end
      n_checks++;
      if (locked_o !== 1'b1 || comma_lane_o !== 3'd5) begin
         n_errors++; $display("FAIL lane5_lock locked=%b lane=%0d want locked=1 lane=5", locked_o, comma_lane_o);
      end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         good_step(0);
         if (err_o === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses != UNLOCK_CNT) begin
         n_errors++; $display("FAIL switch_err_pulses got=%0d want=%0d", pulses, UNLOCK_CNT);
      end
      n_checks++;
      if (locked_o !== 1'b0 || lock_loss_cnt_o !== 8'd1) begin
         n_errors++; $display("FAIL switch_unlock locked=%b loss=%0d want locked=0 loss=1", locked_o, lock_loss_cnt_o);
      end
      n = 0;
      while (locked_o !== 1'b1 && n < 30) begin good_step(0); n++; end
      n_checks++;
      if (locked_o !== 1'b1 || comma_lane_o !== 3'd0 || lock_loss_cnt_o !== 8'd1) begin
         n_errors++; $display("FAIL relock_lane0 locked=%b lane=%0d loss=%0d want 1/0/1", locked_o, comma_lane_o, lock_loss_cnt_o);
      end
   endtask

   task automatic test_burst_errors();
      logic [63:0] bad;
      logic [CW-1:0] e0;
      bit stayed;
      bad = pat_d(0);
      bad[31:24] = 8'h4B;
      e0 = m_errc;
      stayed = 1;
      for (int b = 0; b < 2; b++) begin
         repeat (3) begin step(1'b1, 1'b0, bad, pat_k(0), 8'h00, 8'h00); if (locked_o !== 1'b1) stayed = 0; end
         repeat (4) begin good_step(0); if (locked_o !== 1'b1) stayed = 0; end
         n_checks++;
         if (err_cnt_o !== e0 + CW'(3 * (b + 1))) begin
            n_errors++; $display("FAIL burst_err_cnt burst=%0d got=%0d want=%0d", b, err_cnt_o, e0 + CW'(3 * (b + 1)));
         end
      end
      n_checks++;
      if (!stayed) begin
         n_errors++; $display("FAIL burst_lock_kept locked dropped during non-consecutive bursts, want stays 1");
      end
   endtask

   task automatic test_clear();
      logic [63:0] bad;
      bad = pat_d(0);
      bad[7:0] = 8'h4A;
      step(1'b1, 1'b1, bad, pat_k(0), 8'h00, 8'h00);
      good_step(0);
      n_checks++;
      if (word_cnt_o !== '0 || err_cnt_o !== '0 || lock_loss_cnt_o !== 8'd0 || locked_o !== 1'b1) begin
         n_errors++;
         $display("FAIL clear_priority word=%0d err=%0d loss=%0d locked=%b want 0/0/0/1",
                  word_cnt_o, err_cnt_o, lock_loss_cnt_o, locked_o);
      end
      good_step(0);
      n_checks++;
      if (word_cnt_o !== CW'(1)) begin
         n_errors++; $display("FAIL clear_resume word=%0d want=1", word_cnt_o);
      end
   endtask

   task automatic test_code_err();
      logic [CW-1:0] e0;
      e0 = m_errc;
      step(1'b1, 1'b0, pat_d(0), pat_k(0), 8'h00, 8'h04);
      good_step(0);
      good_step(0);
      n_checks++;
      if (err_cnt_o !== e0 + CW'(CE_EN) || locked_o !== 1'b1) begin
         n_errors++; $display("FAIL code_err err_cnt=%0d want=%0d locked=%b", err_cnt_o, e0 + CW'(CE_EN), locked_o);
      end
   endtask

   task automatic test_enable_drop();
      logic [CW-1:0] w0;
      int n;
      repeat (3) step(1'b0, 1'b0, pat_d(0), pat_k(0), 8'h00, 8'h00);
      n_checks++;
      if (locked_o !== 1'b0 || comma_lane_o !== 3'd0) begin
         n_errors++; $display("FAIL en_low_idle locked=%b lane=%0d want 0/0", locked_o, comma_lane_o);
      end
      w0 = m_word;
      repeat (7) good_step(0);
      repeat (2) step(1'b0, 1'b0, pat_d(0), pat_k(0), 8'h00, 8'h00);
      n_checks++;
      if (locked_o !== 1'b0 || comma_lane_o !== 3'd0) begin
         n_errors++; $display("FAIL verify_drop locked=%b lane=%0d want 0/0", locked_o, comma_lane_o);
      end
      n = 0;
      while (locked_o !== 1'b1 && n < 30) begin good_step(0); n++; end
      n_checks++;
      if (n != 2 + LOCK_CNT) begin
         n_errors++; $display("FAIL relock_time got=%0d cycles want=%0d", n, 2 + LOCK_CNT);
      end
      n_checks++;
      if (word_cnt_o !== w0) begin
         n_errors++; $display("FAIL count_hold word=%0d want=%0d", word_cnt_o, w0);
      end
   endtask

   task automatic test_random();
      int cl, r, b;
      logic en, clr;
      logic [63:0] d;
      logic [7:0] k, de;
      cl = 0;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         d = pat_d(cl); k = pat_k(cl); de = 8'h00; en = 1'b1; clr = 1'b0;
         if (r < 12) begin
            b = $urandom_range(0, 7);
            d[8*b +: 8] = d[8*b +: 8] ^ 8'($urandom_range(1, 255));
         end else if (r < 16) begin
            d = {$urandom, $urandom}; k = 8'($urandom);
         end else if (r < 20) begin
            cl = $urandom_range(0, 7);
         end
         if ($urandom_range(0, 99) < 3) en = 1'b0;
         if ($urandom_range(0, 99) < 3) clr = 1'b1;
         if ($urandom_range(0, 99) < 4) de = 8'(1 << $urandom_range(0, 7));
         step(en, clr, d, k, 8'h00, de);
         n_checks++;
         if ({locked_o, comma_lane_o, err_o, word_cnt_o, err_cnt_o, lock_loss_cnt_o} !==
             {m_locked, m_lane, m_err, m_word, m_errc, m_loss}) begin
            n_errors++;
            $display("FAIL random step=%0d got lk=%b ln=%0d e=%b w=%0d ec=%0d ll=%0d want lk=%b ln=%0d e=%b w=%0d ec=%0d ll=%0d",
                     i, locked_o, comma_lane_o, err_o, word_cnt_o, err_cnt_o, lock_loss_cnt_o,
                     m_locked, m_lane, m_err, m_word, m_errc, m_loss);
         end
      end
   endtask

   task automatic test_saturation();
      for (int it = 0; it < 260; it++) begin
         repeat (12) good_step(0);
         repeat (5) step(1'b1, 1'b0, {8{FILL}}, 8'h00, 8'h00, 8'h00);
      end
      n_checks++;
      if (lock_loss_cnt_o !== 8'hFF || m_loss !== 8'hFF) begin
         n_errors++; $display("FAIL sat_loss got=%0d model=%0d want=255", lock_loss_cnt_o, m_loss);
      end
      n_checks++;
      if (err_cnt_o !== {CW{1'b1}} || word_cnt_o !== {CW{1'b1}}) begin
         n_errors++; $display("FAIL sat_counts err=%0d word=%0d want both %0d", err_cnt_o, word_cnt_o, {CW{1'b1}});
      end
   endtask

   task automatic test_async_reset();
      repeat (12) good_step(0);
      n_checks++;
      if (locked_o !== 1'b1) begin
         n_errors++; $display("FAIL pre_reset_lock locked=%b want=1", locked_o);
      end
      rx_rstn_i = 1'b0;
      #1;
      n_checks++;
      if ({locked_o, comma_lane_o, err_o, word_cnt_o, err_cnt_o, lock_loss_cnt_o} !== '0) begin
         n_errors++; $display("FAIL async_reset locked=%b word=%0d err=%0d loss=%0d want all 0",
                              locked_o, word_cnt_o, err_cnt_o, lock_loss_cnt_o);
      end
      #1;
      rx_rstn_i = 1'b1;
      model_reset();
   endtask

   initial begin
      test_reset();
      test_lane0_lock();
      test_lane_switch();
      test_burst_errors();
      test_clear();
      test_code_err();
      test_enable_drop();
      test_random();
      test_saturation();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
